// File: rtl/color_fsm_scheduler.sv
// Round-robin scheduler that owns the Color FSM command port: grants requesters
// whose color is already held, and issues/confirms a toggle for those that need a switch.
module color_fsm_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int MIN_DWELL = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  logic [NUM_REQ-1:0] req_color_i,
   output logic [NUM_REQ-1:0] req_ready_o,
   output logic [1:0]         fsm_in_o,
   input  logic [1:0]         fsm_out_i,
   output logic               cur_color_o,
   output logic               busy_o,
   output logic               err_o
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int DW = $clog2(MIN_DWELL + 1);
   localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
   localparam logic [1:0] CMD_TOGGLE = 2'h1;
   localparam logic [1:0] CMD_NOP    = 2'h3;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CONFIRM} state_t;

   state_t          state_q, state_d;
   logic            color_q, color_d;
   logic            err_q, err_d;
   logic [PW-1:0]   rr_q, rr_d;
   logic [PW-1:0]   win_q, win_d;
   logic            tgt_q, tgt_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic [1:0]      fsm_in_q;
   logic            busy_q;

   logic            found;
   logic [PW-1:0]   pick, cand;
   logic            fsm_ok, fsm_col;
   logic [NUM_REQ-1:0] ready;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(NUM_REQ - 1)) ? '0 : p + PW'(1);
   endfunction

   // First valid requester at or above the rr pointer, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = rr_q;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = PW'((int'(rr_q) + i) % NUM_REQ);
         if (!found && req_valid_i[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign fsm_ok  = (fsm_out_i == 2'h1) || (fsm_out_i == 2'h2);
   assign fsm_col = fsm_out_i[1];

   always_comb begin
      state_d = state_q;
      color_d = color_q;
      err_d   = err_q;
      rr_d    = rr_q;
      win_d   = win_q;
      tgt_d   = tgt_q;
      dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DW'(1);
      ready   = '0;
      case (state_q)
         S_IDLE: begin
            if (!fsm_ok || fsm_col != color_q) begin
               err_d = 1'b1;
               if (fsm_ok) color_d = fsm_col;
            end else if (found) begin
               if (req_color_i[pick] == color_q) begin
                  ready[pick] = 1'b1;
                  rr_d        = next_ptr(pick);
               end else if (dwell_q == DWELL_MAX) begin
                  win_d   = pick;
                  tgt_d   = req_color_i[pick];
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_d = S_CONFIRM;
         S_CONFIRM: begin
            state_d = S_IDLE;
            if (fsm_ok && fsm_col == tgt_q) begin
               color_d      = tgt_q;
               ready[win_q] = 1'b1;
               rr_d         = next_ptr(win_q);
               // Cleared this cycle, so it already reads 1 on the next.
               dwell_d      = DW'(1);
            end else begin
               err_d = 1'b1;
               if (fsm_ok) color_d = fsm_col;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         color_q  <= 1'b1;
         err_q    <= 1'b0;
         rr_q     <= '0;
         win_q    <= '0;
         tgt_q    <= 1'b0;
         dwell_q  <= DWELL_MAX;
         fsm_in_q <= CMD_NOP;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         color_q  <= color_d;
         err_q    <= err_d;
         rr_q     <= rr_d;
         win_q    <= win_d;
         tgt_q    <= tgt_d;
         dwell_q  <= dwell_d;
         fsm_in_q <= (state_d == S_ISSUE) ? CMD_TOGGLE : CMD_NOP;
         busy_q   <= (state_d != S_IDLE);
      end
   end

   assign req_ready_o = ready;
   assign fsm_in_o    = fsm_in_q;
   assign cur_color_o = color_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_color_fsm_scheduler.sv
// Vector-table bench for color_fsm_scheduler with a behavioural Color FSM
// (reset Red, toggles on 2'h1) that can be stalled or overridden.
module tb_color_fsm_scheduler;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] vld = '0, col = '0;
   logic [N-1:0] rdy;
   logic [1:0]   fin, fout;
   logic         cur, busy, err;
   logic         stuck = 1'b0, frc = 1'b0;
   logic [1:0]   code = 2'h0;
   logic         red_q;

   int n_vec = 0, n_miss = 0;

   always #5 clk = ~clk;

   color_fsm_scheduler #(.NUM_REQ(N), .MIN_DWELL(4)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(vld), .req_color_i(col),
      .req_ready_o(rdy), .fsm_in_o(fin), .fsm_out_i(fout),
      .cur_color_o(cur), .busy_o(busy), .err_o(err)
   );

   // Color FSM model
   always @(posedge clk) begin
      if (rst) red_q <= 1'b1;
      else if (fin == 2'h1 && !stuck) red_q <= ~red_q;
   end
   assign fout = frc ? code : (red_q ? 2'h2 : 2'h1);

   typedef struct {
      logic       rst, stuck, frc;
      logic [1:0] code;
      logic [3:0] vld, col;
      logic [3:0] rdy;
      logic [1:0] fin;
      logic       cur, busy, err;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [1:0] c,
                               input logic [3:0] v, input logic [3:0] cl, input logic [3:0] rd,
                               input logic [1:0] fi, input logic cu, input logic b, input logic e);
      vec_t t;
      t.rst = r; t.stuck = s; t.frc = f; t.code = c; t.vld = v; t.col = cl;
      t.rdy = rd; t.fin = fi; t.cur = cu; t.busy = b; t.err = e;
      return t;
   endfunction

   task automatic apply(input vec_t v);
      @(posedge clk);
      #1;
      rst = v.rst; stuck = v.stuck; frc = v.frc; code = v.code; vld = v.vld; col = v.col;
      sb.push_back(v);
   endtask

   always @(negedge clk) begin : chk
      vec_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_vec++;
         if ({rdy, fin, cur, busy, err} !== {e.rdy, e.fin, e.cur, e.busy, e.err}) begin
            n_miss++;
            $display("FAIL vec%0d: got rdy=%b fin=%h cur=%b busy=%b err=%b, want rdy=%b fin=%h cur=%b busy=%b err=%b",
                     n_vec - 1, rdy, fin, cur, busy, err, e.rdy, e.fin, e.cur, e.busy, e.err);
         end
      end
   end

   initial begin
      int lat;
      //                 rst stk frc code vld      col      rdy      fin  cur busy err
      // reset state, same-color 0-latency grant, then Blue switch for req1
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0000, 4'b0000, 4'b0000, 2'h3, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0001, 4'b0001, 4'b0001, 2'h3, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0000, 4'b0000, 4'b0000, 2'h3, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0010, 4'b0000, 4'b0000, 2'h3, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0010, 4'b0000, 4'b0000, 2'h1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0010, 4'b0000, 4'b0010, 2'h3, 1, 1, 0));
      // req2 Red pending right after confirm: held off by dwell, issue at C+5
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0100, 4'b0100, 4'b0000, 2'h3, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0100, 4'b0100, 4'b0000, 2'h1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0100, 4'b0100, 4'b0100, 2'h3, 0, 1, 0));
      // round-robin alternation between two same-color requesters
      for (int i = 0; i < 2; i++) begin
         tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0101, 4'b0101, 4'b0001, 2'h3, 1, 0, 0));
         tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0101, 4'b0101, 4'b0100, 2'h3, 1, 0, 0));
      end
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0000, 4'b0000, 4'b0000, 2'h3, 1, 0, 0));
      // FSM ignores the toggle: err, no grant, same requester retried
      tbl.push_back(mk(0, 1, 0, 2'h0, 4'b0010, 4'b0000, 4'b0000, 2'h3, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 2'h0, 4'b0010, 4'b0000, 4'b0000, 2'h1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 0, 2'h0, 4'b0010, 4'b0000, 4'b0000, 2'h3, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0010, 4'b0000, 4'b0000, 2'h3, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0010, 4'b0000, 4'b0000, 2'h1, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0010, 4'b0000, 4'b0010, 2'h3, 1, 1, 1));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0000, 4'b0000, 4'b0000, 2'h3, 0, 0, 1));
      // reset during ISSUE abandons the switch
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0001, 4'b0001, 4'b0000, 2'h3, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 2'h0, 4'b0001, 4'b0001, 4'b0000, 2'h1, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0000, 4'b0000, 4'b0000, 2'h3, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0010, 4'b0000, 4'b0000, 2'h3, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0010, 4'b0000, 4'b0000, 2'h1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0010, 4'b0000, 4'b0010, 2'h3, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0000, 4'b0000, 4'b0000, 2'h3, 0, 0, 0));
      // IDLE consistency: invalid code suppresses grant; valid mismatch resyncs
      tbl.push_back(mk(0, 0, 1, 2'h3, 4'b0010, 4'b0000, 4'b0000, 2'h3, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0010, 4'b0000, 4'b0010, 2'h3, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 2'h2, 4'b0000, 4'b0000, 4'b0000, 2'h3, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0000, 4'b0000, 4'b0000, 2'h3, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 2'h0, 4'b0000, 4'b0000, 4'b0000, 2'h3, 0, 0, 1));

      rst = 1'b1;
      repeat (2) @(posedge clk);
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
      @(posedge clk);
      #1 vld = '0; frc = 1'b0; stuck = 1'b0;

      // Hand sequence: fresh reset, Blue request, bounded wait for the grant
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; vld = 4'b0100; col = 4'b0000;
      lat = -1;
      for (int n = 0; n < 10; n++) begin
         #3;
         if (rdy[2]) begin
            lat = n;
            break;
         end
         @(posedge clk);
         #1;
      end
      n_vec++;
      if (lat != 2) begin
         n_miss++;
         $display("FAIL switch_latency: got %0d cycles, want 2", lat);
      end
      @(posedge clk);
      #1 vld = '0;
      #3;
      n_vec++;
      if (cur !== 1'b0) begin
         n_miss++;
         $display("FAIL cur_after_switch: got %b, want 0", cur);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
